brick_wall: RTL and testbench

- Parametrised brick field for the Breakout game; replaces the per-instance single-brick block with one ROWS x COLS array.
- Owns the alive bit of every brick. Runs one ball-collision scan per frame and reports a hit pulse and bounce side to the ball and score logic.
- Provides a registered per-pixel brick-on flag and row index to the colouring logic.
- Asserts endgame when every brick has been destroyed.

---
 rtl/brick_pkg.sv | 20 ++
 rtl/brick_geom.sv | 38 +++
 rtl/brick_wall.sv | 155 +++++++++++++++
 tb/tb_brick_wall.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared types, widths and geometry helper for the Breakout brick wall.
package brick_pkg;

  localparam int COORD_W = 10;
  localparam int CALC_W  = 11;

  typedef logic signed [CALC_W-1:0] calc_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  // Centre of brick number n along one axis: origin + half + 2*half*n.
  function automatic calc_t brick_ctr(input int n, input int origin, input int half);
    return calc_t'(origin + half + 2 * half * n);
  endfunction

endpackage

// File: rtl/brick_geom.sv
// Combinational ball-vs-brick test for a single brick index: bounding-box
// overlap and which axis the ball should reflect on.
module brick_geom
  import brick_pkg::*;
#(
  parameter int COLS    = 10,
  parameter int W_BLOCK = 32,
  parameter int H_BLOCK = 8,
  parameter int X0      = 0,
  parameter int Y0      = 0,
  parameter int R_BALL  = 8,
  parameter int IDX_W   = 5
) (
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [COORD_W-1:0] x_ball_i,
  input  logic [COORD_W-1:0] y_ball_i,
  output logic               overlap_o,
  output logic               side_o
);

  localparam calc_t HW = calc_t'(W_BLOCK);
  localparam calc_t HH = calc_t'(H_BLOCK);
  localparam calc_t RB = calc_t'(R_BALL);

  calc_t xc, yc, xb, yb;

  always_comb begin
    xc = brick_ctr(int'(idx_i) % COLS, X0, W_BLOCK);
    yc = brick_ctr(int'(idx_i) / COLS, Y0, H_BLOCK);
    xb = calc_t'({1'b0, x_ball_i});
    yb = calc_t'({1'b0, y_ball_i});
    overlap_o = (xb - RB <= xc + HW) && (xb + RB >= xc - HW) &&
                (yb - RB <= yc + HH) && (yb + RB >= yc - HH);
    // Ball centre inside the brick's x span means it came through top/bottom.
    side_o = !((xb >= xc - HW) && (xb <= xc + HW));
  end

endmodule

// File: rtl/brick_wall.sv
// ROWS x COLS brick field: alive bits, per-frame collision scan, pixel
// lookup for the colouring logic and end-of-game detection.
module brick_wall
  import brick_pkg::*;
#(
  parameter int ROWS    = 3,
  parameter int COLS    = 10,
  parameter int W_BLOCK = 32,
  parameter int H_BLOCK = 8,
  parameter int X0      = 0,
  parameter int Y0      = 0,
  parameter int R_BALL  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          restart,
  input  logic                          frame_tick,
  input  logic [9:0]                    x_ball,
  input  logic [9:0]                    y_ball,
  input  logic [9:0]                    next_x,
  input  logic [9:0]                    next_y,
  output logic                          pixel_on,
  output logic [$clog2(ROWS)-1:0]       pixel_row,
  output logic                          hit_block,
  output logic                          hit_side,
  output logic [$clog2(ROWS*COLS+1)-1:0] remaining,
  output logic [7:0]                    hit_count,
  output logic                          endgame
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam int REM_W = $clog2(N + 1);
  localparam int ROW_W = $clog2(ROWS);
  localparam int XSH   = $clog2(2 * W_BLOCK);
  localparam int YSH   = $clog2(2 * H_BLOCK);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [COORD_W-1:0]   xb_q, yb_q;
  logic [N-1:0]         alive_q;
  logic [REM_W-1:0]     remaining_q;
  logic [7:0]           hit_count_q;
  logic                 hit_side_q, endgame_q, pixel_on_q;
  logic [ROW_W-1:0]     pixel_row_q;
  logic                 overlap, side, hit;
  calc_t                px, py, pc, pr;
  logic                 pix_on_d;
  logic [ROW_W-1:0]     pix_row_d;
  logic [IDX_W-1:0]     pix_idx;

  brick_geom #(
    .COLS(COLS), .W_BLOCK(W_BLOCK), .H_BLOCK(H_BLOCK),
    .X0(X0), .Y0(Y0), .R_BALL(R_BALL), .IDX_W(IDX_W)
  ) u_geom (
    .idx_i    (idx_q),
    .x_ball_i (xb_q),
    .y_ball_i (yb_q),
    .overlap_o(overlap),
    .side_o   (side)
  );

  assign hit = (state_q == SCAN) && alive_q[idx_q] && overlap;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_tick) state_d = SCAN;
      SCAN:    if (hit) state_d = REPORT;
               else if (idx_q == LAST) state_d = IDLE;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (restart) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pixel lookup: negative offsets (left of / above the wall) are off.
  always_comb begin
    px        = calc_t'({1'b0, next_x}) - calc_t'(X0);
    py        = calc_t'({1'b0, next_y}) - calc_t'(Y0);
    pc        = px >>> XSH;
    pr        = py >>> YSH;
    pix_idx   = IDX_W'(pr * calc_t'(COLS) + pc);
    pix_on_d  = 1'b0;
    pix_row_d = '0;
    if (!px[CALC_W-1] && !py[CALC_W-1] && pc < calc_t'(COLS) && pr < calc_t'(ROWS)) begin
      pix_on_d  = alive_q[pix_idx];
      pix_row_d = ROW_W'(pr);
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == IDLE && frame_tick) begin
      xb_q <= x_ball;
      yb_q <= y_ball;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      alive_q     <= '1;
      remaining_q <= REM_W'(N);
      hit_count_q <= '0;
      hit_side_q  <= 1'b0;
      endgame_q   <= 1'b0;
      pixel_on_q  <= 1'b0;
      pixel_row_q <= '0;
    end else if (restart) begin
      idx_q       <= '0;
      alive_q     <= '1;
      remaining_q <= REM_W'(N);
      hit_count_q <= '0;
      hit_side_q  <= 1'b0;
      endgame_q   <= 1'b0;
      pixel_on_q  <= 1'b0;
      pixel_row_q <= '0;
    end else begin
      pixel_on_q  <= pix_on_d;
      pixel_row_q <= pix_row_d;
      endgame_q   <= (remaining_q == '0);
      case (state_q)
        IDLE: if (frame_tick) idx_q <= '0;
        SCAN: begin
          if (hit) begin
            alive_q[idx_q] <= 1'b0;
            hit_side_q     <= side;
          end else if (idx_q != LAST) begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        REPORT: begin
          remaining_q <= remaining_q - REM_W'(1);
          if (hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign hit_block = (state_q == REPORT);
  assign hit_side  = hit_side_q;
  assign remaining = remaining_q;
  assign hit_count = hit_count_q;
  assign endgame   = endgame_q;
  assign pixel_on  = pixel_on_q;
  assign pixel_row = pixel_row_q;

endmodule

// File: tb/tb_brick_wall.sv
// Self-checking bench for brick_wall against a brick-list reference model.
module tb_brick_wall;

  localparam int ROWS = 3, COLS = 10, W = 32, H = 8, X0 = 0, Y0 = 0, R = 8;
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(N + 1);

  logic clock = 1'b0, reset = 1'b0, restart = 1'b0, frame_tick = 1'b0;
  logic [9:0] x_ball = '0, y_ball = '0, next_x = '0, next_y = '0;
  logic pixel_on, hit_block, hit_side, endgame;
  logic [$clog2(ROWS)-1:0] pixel_row;
  logic [RW-1:0] remaining;
  logic [7:0] hit_count;

  int n_checks = 0, n_fail = 0;
  bit m_alive[N];
  int m_rem, m_cnt;

  brick_wall #(.ROWS(ROWS), .COLS(COLS), .W_BLOCK(W), .H_BLOCK(H),
               .X0(X0), .Y0(Y0), .R_BALL(R)) dut (
    .clock(clock), .reset(reset), .restart(restart), .frame_tick(frame_tick),
    .x_ball(x_ball), .y_ball(y_ball), .next_x(next_x), .next_y(next_y),
    .pixel_on(pixel_on), .pixel_row(pixel_row), .hit_block(hit_block),
    .hit_side(hit_side), .remaining(remaining), .hit_count(hit_count),
    .endgame(endgame)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
    m_rem = N;
    m_cnt = 0;
  endfunction

  function automatic int ctr_x(input int i);
    return X0 + W + 2 * W * (i % COLS);
  endfunction

  function automatic int ctr_y(input int i);
    return Y0 + H + 2 * H * (i / COLS);
  endfunction

  // First alive brick whose rectangle meets the ball's bounding box.
  function automatic int model_pick(input int x, input int y);
    for (int i = 0; i < N; i++)
      if (m_alive[i] && x - R <= ctr_x(i) + W && x + R >= ctr_x(i) - W &&
          y - R <= ctr_y(i) + H && y + R >= ctr_y(i) - H) return i;
    return -1;
  endfunction

  function automatic int lowest_alive();
    for (int i = 0; i < N; i++) if (m_alive[i]) return i;
    return -1;
  endfunction

  function automatic void model_kill(input int i);
    m_alive[i] = 1'b0;
    m_rem--;
    if (m_cnt < 255) m_cnt++;
  endfunction

  // Pulse frame_tick with the given ball and observe the following cycles.
  task automatic tick_watch(input int x, input int y, output int hit_k, output logic side,
                            output int nhits, output logic eg1, output logic eg2, output int rem1);
    x_ball = 10'(x); y_ball = 10'(y); frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    hit_k = -1; nhits = 0; side = 1'b0; eg1 = 1'b0; eg2 = 1'b0; rem1 = -1;
    for (int k = 1; k <= N + 4; k++) begin
      if (hit_block === 1'b1) begin
        nhits++;
        if (hit_k < 0) begin hit_k = k; side = hit_side; end
      end
      if (hit_k > 0 && k == hit_k + 1) begin eg1 = endgame; rem1 = int'(remaining); end
      if (hit_k > 0 && k == hit_k + 2) eg2 = endgame;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (pixel_on !== 1'b0 || hit_block !== 1'b0 || endgame !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: pixel_on=%b hit_block=%b endgame=%b, want 0 0 0", pixel_on, hit_block, endgame);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    n_checks++;
    if (remaining !== RW'(N) || hit_count !== 8'd0 || hit_side !== 1'b0) begin
      n_fail++; $display("FAIL reset_counts: remaining=%0d hit_count=%0d hit_side=%b, want %0d 0 0", remaining, hit_count, hit_side, N);
    end
    next_x = 10'd40; next_y = 10'd8;
    @(posedge clock); #1;
    n_checks++;
    if (pixel_on !== 1'b1 || pixel_row !== 2'd0) begin
      n_fail++; $display("FAIL reset_pixel: pixel_on=%b row=%0d, want 1 0", pixel_on, pixel_row);
    end
  endtask

  task automatic test_pixels(input int n);
    int nx, ny, c, r;
    logic exp_on;
    for (int i = 0; i < n; i++) begin
      nx = (i == 0) ? 40 : (i == 1) ? 700 : int'($urandom_range(0, 767));
      ny = (i == 0) ? 8 : (i == 1) ? 5 : int'($urandom_range(0, 63));
      c = (nx - X0) / (2 * W); r = (ny - Y0) / (2 * H);
      exp_on = (nx >= X0 && ny >= Y0 && c < COLS && r < ROWS) ? m_alive[r * COLS + c] : 1'b0;
      next_x = 10'(nx); next_y = 10'(ny);
      @(posedge clock); #1;
      n_checks++;
      if (pixel_on !== exp_on || (exp_on && pixel_row !== 2'(r))) begin
        n_fail++; $display("FAIL pixel(%0d,%0d): on=%b row=%0d, want on=%b row=%0d", nx, ny, pixel_on, pixel_row, exp_on, r);
      end
    end
  endtask

  task automatic test_hits(input int nrand);
    int xs[$] = '{48, 72, 72, 72, 72};
    int ys[$] = '{20, 40, 40, 40, 40};
    int hk, nh, rem1, exp_i;
    logic sd, e1, e2, exp_side;
    for (int i = 0; i < nrand; i++) begin
      xs.push_back(int'($urandom_range(0, 639)));
      ys.push_back(int'($urandom_range(0, 60)));
    end
    foreach (xs[f]) begin
      exp_i = model_pick(xs[f], ys[f]);
      exp_side = (exp_i >= 0) ? !(xs[f] >= ctr_x(exp_i) - W && xs[f] <= ctr_x(exp_i) + W) : 1'b0;
      tick_watch(xs[f], ys[f], hk, sd, nh, e1, e2, rem1);
      if (exp_i >= 0) model_kill(exp_i);
      n_checks++;
      if (hk != ((exp_i < 0) ? -1 : 2 + exp_i) || nh != ((exp_i < 0) ? 0 : 1)) begin
        n_fail++; $display("FAIL hit_timing ball(%0d,%0d): hit at +%0d pulses=%0d, want brick %0d", xs[f], ys[f], hk, nh, exp_i);
      end
      n_checks++;
      if (exp_i >= 0 && sd !== exp_side) begin
        n_fail++; $display("FAIL hit_side ball(%0d,%0d): side=%b, want %b", xs[f], ys[f], sd, exp_side);
      end
      n_checks++;
      if (remaining !== RW'(m_rem) || hit_count !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL counts: remaining=%0d hit_count=%0d, want %0d %0d", remaining, hit_count, m_rem, m_cnt);
      end
    end
  endtask

  task automatic test_scan_miss();
    int j, hk, nh;
    j = lowest_alive();
    x_ball = 10'd300; y_ball = 10'd200; frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    hk = -1; nh = 0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 30) begin x_ball = 10'(ctr_x(j)); y_ball = 10'(ctr_y(j)); frame_tick = 1'b1; end
      if (k == 32) frame_tick = 1'b0;
      if (hit_block === 1'b1) begin nh++; if (hk < 0) hk = k; end
      @(posedge clock); #1;
    end
    model_kill(j);
    n_checks++;
    if (hk != 33 + j || nh != 1) begin
      n_fail++; $display("FAIL scan_miss_then_idle: hit at +%0d pulses=%0d, want +%0d 1", hk, nh, 33 + j);
    end
  endtask

  task automatic test_restart();
    int nh, hk, rem1;
    logic sd, e1, e2;
    x_ball = 10'd608; y_ball = 10'd40; frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    nh = 0;
    for (int k = 1; k <= N + 4; k++) begin
      restart = (k == 4);
      if (hit_block === 1'b1) nh++;
      @(posedge clock); #1;
    end
    restart = 1'b0;
    model_reset();
    n_checks++;
    if (nh != 0 || remaining !== RW'(N) || hit_count !== 8'd0 || endgame !== 1'b0) begin
      n_fail++; $display("FAIL restart_mid_scan: pulses=%0d remaining=%0d hit_count=%0d endgame=%b, want 0 %0d 0 0", nh, remaining, hit_count, endgame, N);
    end
    x_ball = 10'd48; y_ball = 10'd20; frame_tick = 1'b1; restart = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0; restart = 1'b0;
    nh = 0;
    for (int k = 1; k <= N + 4; k++) begin
      if (hit_block === 1'b1) nh++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (nh != 0 || remaining !== RW'(N)) begin
      n_fail++; $display("FAIL restart_with_tick: pulses=%0d remaining=%0d, want 0 %0d", nh, remaining, N);
    end
    tick_watch(48, 20, hk, sd, nh, e1, e2, rem1);
    model_kill(0);
    n_checks++;
    if (hk != 2 || nh != 1 || sd !== 1'b0) begin
      n_fail++; $display("FAIL restart_then_idle: hit at +%0d pulses=%0d side=%b, want +2 1 0", hk, nh, sd);
    end
  endtask

  task automatic test_clear_all();
    int j, hk, nh, rem1, f;
    logic sd, e1, e2;
    restart = 1'b1;
    @(posedge clock); #1 restart = 1'b0;
    model_reset();
    f = 0;
    while (lowest_alive() >= 0 && f < N) begin
      j = lowest_alive();
      tick_watch(ctr_x(j), ctr_y(j), hk, sd, nh, e1, e2, rem1);
      model_kill(j);
      n_checks++;
      if (hk != 2 + j || nh != 1 || sd !== 1'b0 || rem1 != m_rem) begin
        n_fail++; $display("FAIL clear_brick_%0d: hit at +%0d pulses=%0d side=%b rem=%0d, want +%0d 1 0 %0d", j, hk, nh, sd, rem1, 2 + j, m_rem);
      end
      n_checks++;
      if (e1 !== 1'b0 || e2 !== (m_rem == 0)) begin
        n_fail++; $display("FAIL endgame_timing brick %0d: eg(+1)=%b eg(+2)=%b, want 0 %b", j, e1, e2, m_rem == 0);
      end
      f++;
    end
    n_checks++;
    if (endgame !== 1'b1 || remaining !== RW'(0) || hit_count !== 8'd30) begin
      n_fail++; $display("FAIL cleared_state: endgame=%b remaining=%0d hit_count=%0d, want 1 0 30", endgame, remaining, hit_count);
    end
    tick_watch(48, 20, hk, sd, nh, e1, e2, rem1);
    n_checks++;
    if (nh != 0 || endgame !== 1'b1 || hit_count !== 8'd30) begin
      n_fail++; $display("FAIL post_endgame_tick: pulses=%0d endgame=%b hit_count=%0d, want 0 1 30", nh, endgame, hit_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pixels(12);
    test_hits(20);
    test_pixels(24);
    test_scan_miss();
    test_restart();
    test_clear_all();
    test_pixels(12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
